// File: rtl/opb_master_arbiter_pkg.sv
// Shared types and helpers for the OPB master arbiter and its round-robin picker.
// Imported by the interface, the picker and the top.
package opb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_XFER  = 2'd2
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT_CYCLES = 16;

  // Index width for a value range of 0..value-1, never less than one bit.
  function automatic int clog2(input int value);
    int width;
    width = 1;
    while ((32'sd1 <<< width) < value) begin
      width = width + 1;
    end
    return width;
  endfunction

endpackage

// File: rtl/opb_master_arbiter_if.sv
// Request/select/lock/ack bundle between OPB masters and the master arbiter.
// The arbiter connects through the slave modport.
interface opb_master_arbiter_if #(
  parameter int N_MASTERS = 4
);
  import opb_arb_pkg::*;

  localparam int OW = clog2(N_MASTERS);

  logic [0:N_MASTERS-1] M_request;
  logic [0:N_MASTERS-1] M_select;
  logic [0:N_MASTERS-1] M_busLock;
  logic                 OPB_xferAck;
  logic                 OPB_errAck;
  logic                 OPB_retry;
  logic [0:N_MASTERS-1] OPB_MGrant;
  logic                 OPB_timeout;
  logic                 arb_busy;
  logic [OW-1:0]        arb_owner;

  modport master (
    output M_request, M_select, M_busLock, OPB_xferAck, OPB_errAck, OPB_retry,
    input  OPB_MGrant, OPB_timeout, arb_busy, arb_owner
  );

  modport slave (
    input  M_request, M_select, M_busLock, OPB_xferAck, OPB_errAck, OPB_retry,
    output OPB_MGrant, OPB_timeout, arb_busy, arb_owner
  );

endinterface

// File: rtl/opb_master_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
// Generic so other bus bridges can reuse it.
module opb_rr_picker
  import opb_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  localparam int IW = clog2(N_REQ)
) (
  input  logic [0:N_REQ-1] req,
  input  logic [IW-1:0]    ptr,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  // Scan offsets from far to near so the nearest requester after ptr is kept last.
  always_comb begin : scan
    int          sum_s;
    logic [IW-1:0] pos_s;
    valid = 1'b0;
    idx   = '0;
    sum_s = 0;
    pos_s = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      sum_s = (int'(ptr) + off) % N_REQ;
      pos_s = IW'(sum_s);
      idx   = req[pos_s] ? pos_s : idx;
      valid = valid | req[pos_s];
    end
  end

endmodule

// File: rtl/opb_master_arbiter.sv
// OPB master arbiter: round-robin grant, bus-lock re-grant and slave-timeout watchdog.
// All outputs are registered; reset is synchronous and active high.
module opb_master_arbiter
  import opb_arb_pkg::*;
#(
  parameter int N_MASTERS      = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                 OPB_Clk,
  input logic                 OPB_Rst,
  opb_master_arbiter_if.slave bus
);

  localparam int OW = clog2(N_MASTERS);
  localparam int CW = clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] WDOG_LAST = CW'(TIMEOUT_CYCLES - 2);
  localparam logic [OW-1:0] OWNER_MAX = OW'(N_MASTERS - 1);

  arb_state_e           state_r, state_nxt_s;
  logic [0:N_MASTERS-1] grant_r, grant_nxt_s;
  logic                 timeout_r, timeout_nxt_s;
  logic                 busy_r;
  logic [OW-1:0]        owner_r, owner_nxt_s;
  logic [OW-1:0]        rr_ptr_r, rr_ptr_nxt_s;
  logic [OW-1:0]        owner_inc_s, pick_idx_s;
  logic [CW-1:0]        wdog_r, wdog_nxt_s;
  logic                 pick_valid_s, owner_sel_s, owner_keep_s, any_ack_s;

  opb_rr_picker #(.N_REQ(N_MASTERS)) u_picker (
    .req   (bus.M_request),
    .ptr   (rr_ptr_r),
    .valid (pick_valid_s),
    .idx   (pick_idx_s)
  );

  assign owner_sel_s  = bus.M_select[owner_r];
  assign owner_keep_s = bus.M_busLock[owner_r] & bus.M_request[owner_r];
  assign any_ack_s    = bus.OPB_xferAck | bus.OPB_errAck | bus.OPB_retry;
  assign owner_inc_s  = (owner_r == OWNER_MAX) ? '0 : owner_r + OW'(1);

  // State and registered outputs; busy follows the state being entered.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= '0;
      timeout_r <= 1'b0;
      busy_r    <= 1'b0;
      owner_r   <= '0;
      rr_ptr_r  <= '0;
      wdog_r    <= '0;
    end else begin
      state_r   <= state_nxt_s;
      grant_r   <= grant_nxt_s;
      timeout_r <= timeout_nxt_s;
      busy_r    <= (state_nxt_s != ST_IDLE);
      owner_r   <= owner_nxt_s;
      rr_ptr_r  <= rr_ptr_nxt_s;
      wdog_r    <= wdog_nxt_s;
    end
  end

  // Next state: only the owner's select and lock influence GRANT/XFER.
  always_comb begin
    state_nxt_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) state_nxt_s = ST_GRANT;
        else              state_nxt_s = ST_IDLE;
      end
      ST_GRANT: begin
        if (owner_sel_s) state_nxt_s = ST_XFER;
        else             state_nxt_s = ST_IDLE;
      end
      ST_XFER: begin
        if (owner_sel_s)       state_nxt_s = ST_XFER;
        else if (owner_keep_s) state_nxt_s = ST_GRANT;
        else                   state_nxt_s = ST_IDLE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next output values. The watchdog fires one edge early so the pulse lands
  // in the last quiet cycle, letting an ack in the preceding cycle cancel it.
  always_comb begin
    grant_nxt_s   = '0;
    timeout_nxt_s = 1'b0;
    owner_nxt_s   = owner_r;
    rr_ptr_nxt_s  = rr_ptr_r;
    wdog_nxt_s    = '0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          owner_nxt_s             = pick_idx_s;
          grant_nxt_s[pick_idx_s] = 1'b1;
        end else begin
          owner_nxt_s = owner_r;
        end
      end
      ST_GRANT: begin
        if (owner_sel_s) rr_ptr_nxt_s = rr_ptr_r;
        else             rr_ptr_nxt_s = owner_inc_s;
      end
      ST_XFER: begin
        if (any_ack_s) begin
          wdog_nxt_s = '0;
        end else if (wdog_r == WDOG_LAST) begin
          timeout_nxt_s = 1'b1;
          wdog_nxt_s    = '0;
        end else begin
          wdog_nxt_s = wdog_r + CW'(1);
        end
        if (owner_sel_s) begin
          rr_ptr_nxt_s = rr_ptr_r;
        end else if (owner_keep_s) begin
          grant_nxt_s[owner_r] = 1'b1;
          wdog_nxt_s           = '0;
        end else begin
          rr_ptr_nxt_s = owner_inc_s;
          wdog_nxt_s   = '0;
        end
      end
      default: begin
        grant_nxt_s = '0;
      end
    endcase
  end

  assign bus.OPB_MGrant  = grant_r;
  assign bus.OPB_timeout = timeout_r;
  assign bus.arb_busy    = busy_r;
  assign bus.arb_owner   = owner_r;

endmodule

// File: tb/tb_opb_master_arbiter.sv
// Directed bench for opb_master_arbiter: cycle model compared every cycle plus
// hand-computed checkpoints for grant order, lock re-grant, watchdog and reset.
module tb_opb_master_arbiter;
  import opb_arb_pkg::*;

  localparam int N = 4;
  localparam int T = 16;
  typedef logic [1:0] idx_t;

  logic OPB_Clk = 1'b0;
  logic OPB_Rst = 1'b1;
  always #5 OPB_Clk = ~OPB_Clk;

  opb_master_arbiter_if #(.N_MASTERS(N)) bus();

  opb_master_arbiter #(.N_MASTERS(N), .TIMEOUT_CYCLES(T)) dut (
    .OPB_Clk (OPB_Clk),
    .OPB_Rst (OPB_Rst),
    .bus     (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 granted, 2 transferring.
  int           m_phase;
  idx_t         m_owner, m_ptr, m_p;
  int           m_run;
  logic         m_found;
  logic [0:N-1] e_grant;
  logic         e_to;

  function automatic logic [0:N-1] oh(input idx_t k);
    logic [0:N-1] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  initial begin
    m_phase = 0; m_owner = '0; m_ptr = '0; m_run = 0; e_grant = '0; e_to = 1'b0;
    forever begin
      @(posedge OPB_Clk);
      if (OPB_Rst) begin
        m_phase = 0; m_owner = '0; m_ptr = '0; m_run = 0; e_grant = '0; e_to = 1'b0;
      end else begin
        e_grant = '0;
        e_to    = 1'b0;
        if (m_phase == 0) begin
          m_found = 1'b0;
          for (int off = 0; off < N; off++) begin
            m_p = m_ptr + idx_t'(off);
            if (!m_found && bus.M_request[m_p]) begin
              m_found = 1'b1;
              m_owner = m_p;
            end
          end
          if (m_found) begin
            m_phase = 1;
            e_grant = oh(m_owner);
          end
        end else if (m_phase == 1) begin
          if (bus.M_select[m_owner]) begin
            m_phase = 2;
            m_run   = 0;
          end else begin
            m_phase = 0;
            m_ptr   = m_owner + 2'd1;
          end
        end else begin
          if (bus.OPB_xferAck || bus.OPB_errAck || bus.OPB_retry) begin
            m_run = 0;
          end else begin
            m_run = m_run + 1;
            if (m_run == T - 1) begin
              e_to  = 1'b1;
              m_run = 0;
            end
          end
          if (!bus.M_select[m_owner]) begin
            if (bus.M_busLock[m_owner] && bus.M_request[m_owner]) begin
              m_phase = 1;
              e_grant = oh(m_owner);
            end else begin
              m_phase = 0;
              m_ptr   = m_owner + 2'd1;
            end
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge OPB_Clk);
      if (chk_en) begin
        n_vec++;
        if (bus.OPB_MGrant !== e_grant || bus.OPB_timeout !== e_to ||
            bus.arb_busy !== (m_phase != 0) || bus.arb_owner !== m_owner) begin
          n_err++;
          $display("FAIL cycle_model t=%0t grant=%b/%b timeout=%b/%b busy=%b/%b owner=%0d/%0d (actual/required)",
                   $time, bus.OPB_MGrant, e_grant, bus.OPB_timeout, e_to,
                   bus.arb_busy, (m_phase != 0), bus.arb_owner, m_owner);
        end
      end
    end
  end

  task automatic step();
    @(posedge OPB_Clk);
    #1;
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic wait_grant(output int k);
    idx_t jj;
    k = -1;
    for (int i = 0; i < 8 && k < 0; i++) begin
      step();
      for (int j = 0; j < N; j++) begin
        jj = idx_t'(j);
        if (bus.OPB_MGrant[jj] === 1'b1) k = j;
      end
    end
    if (k < 0) lit("grant_wait_expired", 0, 1);
  endtask

  int order [5];
  int k;
  int n_to;

  initial begin
    bus.M_request = '0; bus.M_select = '0; bus.M_busLock = '0;
    bus.OPB_xferAck = 1'b0; bus.OPB_errAck = 1'b0; bus.OPB_retry = 1'b0;
    OPB_Rst = 1'b1;
    step(); step();
    chk_en = 1'b1;
    lit("reset_grant", int'(bus.OPB_MGrant), 0);
    lit("reset_busy", int'(bus.arb_busy), 0);
    lit("reset_owner", int'(bus.arb_owner), 0);
    lit("reset_timeout", int'(bus.OPB_timeout), 0);
    OPB_Rst = 1'b0;

    // Single master 2 with ack on the third transfer cycle.
    bus.M_request = oh(2'd2);
    step();
    lit("single_grant", int'(bus.OPB_MGrant), int'(oh(2'd2)));
    lit("single_owner", int'(bus.arb_owner), 2);
    bus.M_request = '0; bus.M_select = oh(2'd2);
    step();
    lit("single_grant_one_cycle", int'(bus.OPB_MGrant), 0);
    lit("single_busy_xfer", int'(bus.arb_busy), 1);
    step(); step();
    bus.OPB_xferAck = 1'b1;
    step();
    bus.OPB_xferAck = 1'b0; bus.M_select = '0;
    step();
    lit("single_idle", int'(bus.arb_busy), 0);

    // Pointer now 3: masters 0 and 3 request, 3 wins, then abandons.
    bus.M_request = oh(2'd0) | oh(2'd3);
    step();
    lit("ptr3_owner", int'(bus.arb_owner), 3);
    bus.M_request = '0;
    step();
    lit("abandon_idle", int'(bus.arb_busy), 0);
    lit("abandon_grant", int'(bus.OPB_MGrant), 0);

    // Round robin, all four requesting; pointer restarts at 0.
    bus.M_request = '1;
    for (int r = 0; r < 5; r++) begin
      wait_grant(k);
      order[r] = k;
      bus.M_select = (k >= 0) ? oh(idx_t'(k)) : '0;
      step(); step();
      bus.M_select = '0;
    end
    bus.M_request = '0;
    step();
    lit("rr_0", order[0], 0);
    lit("rr_1", order[1], 1);
    lit("rr_2", order[2], 2);
    lit("rr_3", order[3], 3);
    lit("rr_4", order[4], 0);

    // Bus lock: master 1 keeps the bus for three transfers while master 0 waits.
    bus.M_request = oh(2'd0) | oh(2'd1); bus.M_busLock = oh(2'd1);
    step();
    lit("lock_first_owner", int'(bus.arb_owner), 1);
    for (int t = 0; t < 3; t++) begin
      bus.M_select = oh(2'd1);
      step(); step();
      if (t == 2) begin
        bus.M_busLock = '0; bus.M_request = oh(2'd0);
      end
      bus.M_select = '0;
      step();
      if (t < 2) lit("lock_regrant", int'(bus.OPB_MGrant), int'(oh(2'd1)));
      else       lit("lock_release_idle", int'(bus.arb_busy), 0);
    end
    step();
    lit("lock_then_m0", int'(bus.OPB_MGrant), int'(oh(2'd0)));
    bus.M_request = '0;
    step();

    // Watchdog: no ack, pulse in transfer cycle 16 only.
    bus.M_request = oh(2'd0);
    step();
    bus.M_select = oh(2'd0); bus.M_request = '0;
    step();
    n_to = 0;
    for (int c = 1; c <= T; c++) begin
      step();
      if (bus.OPB_timeout === 1'b1) n_to++;
      if (c == T - 1) lit("timeout_cycle16", int'(bus.OPB_timeout), 1);
    end
    lit("timeout_single_pulse", n_to, 1);
    bus.M_select = '0;
    step();

    // Rerun with an ack in cycle 15: no pulse.
    bus.M_request = oh(2'd0);
    step();
    bus.M_select = oh(2'd0); bus.M_request = '0;
    step();
    n_to = 0;
    for (int c = 1; c <= T + 2; c++) begin
      bus.OPB_xferAck = (c == T - 1);
      step();
      if (bus.OPB_timeout === 1'b1) n_to++;
    end
    bus.OPB_xferAck = 1'b0;
    lit("ack15_suppresses", n_to, 0);
    bus.M_select = '0;
    step();

    // Select drops in the cycle the watchdog fires: pulse and idle together.
    bus.M_request = oh(2'd0);
    step();
    bus.M_select = oh(2'd0); bus.M_request = '0;
    step();
    for (int c = 1; c <= T - 1; c++) begin
      if (c == T - 1) bus.M_select = '0;
      step();
    end
    lit("drop_timeout_pulse", int'(bus.OPB_timeout), 1);
    lit("drop_timeout_idle", int'(bus.arb_busy), 0);
    step();
    lit("drop_timeout_clear", int'(bus.OPB_timeout), 0);

    // Reset in the middle of a transfer; pointer must restart at 0.
    bus.M_request = oh(2'd2);
    step();
    bus.M_select = oh(2'd2); bus.M_request = '0;
    step(); step();
    OPB_Rst = 1'b1;
    step();
    lit("rst_grant", int'(bus.OPB_MGrant), 0);
    lit("rst_busy", int'(bus.arb_busy), 0);
    lit("rst_owner", int'(bus.arb_owner), 0);
    lit("rst_timeout", int'(bus.OPB_timeout), 0);
    bus.M_select = '0; OPB_Rst = 1'b0;
    step();
    bus.M_request = oh(2'd0) | oh(2'd3);
    step();
    lit("rst_ptr_zero", int'(bus.arb_owner), 0);
    bus.M_request = '0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
